// File: rtl/bank_map_pkg.sv
// bank_map_pkg: shared types and the radix-16 digit-sum helper for the bank address mapper.
package bank_map_pkg;
  localparam int RADIX  = 16;
  localparam int LANES  = 16;
  localparam int BANK_W = 4;
  typedef logic [BANK_W-1:0] bank_t;
  typedef logic [BANK_W-1:0] lane_t;
  // 4-bit accumulator, so the mod-16 wrap comes for free; only the low n digits are summed.
  function automatic bank_t digit_sum(input logic [63:0] v, input int n);
    bank_t s;
    s = '0;
    for (int k = 0; k < 16; k++)
      if (k < n) s += v[4*k +: 4];
    return s;
  endfunction
endpackage

// File: rtl/bank_idx_calc.sv
// bank_idx_calc: combinational bank index (digit sum mod 16) and in-bank address for one lane.
module bank_idx_calc
  import bank_map_pkg::*;
#(
  parameter int D_WIDTH    = 12,
  parameter int NUM_DIGITS = D_WIDTH / 4,
  parameter int BA_WIDTH   = D_WIDTH - 4
) (
  input  logic [D_WIDTH-1:0]  order,
  output bank_t               bank,
  output logic [BA_WIDTH-1:0] addr
);
  assign bank = digit_sum(64'(order), NUM_DIGITS);
  assign addr = order[D_WIDTH-1:4];
endmodule

// File: rtl/bank_addr_map.sv
// bank_addr_map: two-stage conflict-free bank mapper with inverse lane routing and conflict tracking.
module bank_addr_map
  import bank_map_pkg::*;
#(
  parameter int D_WIDTH    = 12,
  parameter int NUM_DIGITS = D_WIDTH / 4,
  parameter int BA_WIDTH   = D_WIDTH - 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_done,
  input  logic                clr,
  input  logic [D_WIDTH-1:0]  order [LANES],
  output logic                out_valid,
  output bank_t               bank_idx [LANES],
  output logic [BA_WIDTH-1:0] bank_addr [LANES],
  output lane_t               lane_sel [LANES],
  output logic                conflict,
  output logic [15:0]         group_cnt,
  output logic                map_done
);
  bank_t               b_c [LANES];
  logic [BA_WIDTH-1:0] a_c [LANES];
  logic                v1, d1;
  bank_t               b1 [LANES];
  logic [BA_WIDTH-1:0] a1 [LANES];
  lane_t               ls_c [LANES];
  logic [LANES-1:0]    occ;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bank_idx_calc #(.D_WIDTH(D_WIDTH), .NUM_DIGITS(NUM_DIGITS), .BA_WIDTH(BA_WIDTH)) u_calc (
      .order(order[i]),
      .bank (b_c[i]),
      .addr (a_c[i])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      d1 <= 1'b0;
      b1 <= '{default: '0};
      a1 <= '{default: '0};
    end else begin
      v1 <= in_valid;
      d1 <= in_valid & in_done;
      if (in_valid) begin
        b1 <= b_c;
        a1 <= a_c;
      end
    end
  // Walk lanes high to low so the lowest matching lane is the last writer.
  always_comb begin
    ls_c = '{default: '0};
    occ  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      ls_c[b1[i]] = lane_t'(i);
      occ[b1[i]]  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      bank_idx  <= '{default: '0};
      bank_addr <= '{default: '0};
      lane_sel  <= '{default: '0};
      conflict  <= 1'b0;
      group_cnt <= '0;
      map_done  <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        bank_idx  <= b1;
        bank_addr <= a1;
        lane_sel  <= ls_c;
      end
      conflict  <= clr ? 1'b0 : conflict | (v1 & (occ != '1));
      group_cnt <= clr ? '0 : group_cnt + 16'(v1);
      map_done  <= d1 & ~clr;
    end
endmodule

// File: tb/tb_bank_addr_map.sv
// tb_bank_addr_map: directed vectors with hand-computed expectations for bank_addr_map.
module tb_bank_addr_map;
  import bank_map_pkg::*;
  logic        clk, rst, in_valid, in_done, clr;
  logic [11:0] ord [LANES];
  logic        out_valid, conflict, map_done;
  bank_t       bank_idx [LANES];
  logic [7:0]  bank_addr [LANES];
  lane_t       lane_sel [LANES];
  logic [15:0] group_cnt;
  int n_vec = 0, n_err = 0;
  int ovc = 0, dn = 0, dpos = 0;
  logic [15:0] occ;

  bank_addr_map #(.D_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_done(in_done), .clr(clr),
    .order(ord), .out_valid(out_valid), .bank_idx(bank_idx), .bank_addr(bank_addr),
    .lane_sel(lane_sel), .conflict(conflict), .group_cnt(group_cnt), .map_done(map_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind 0: m*256, kind 1: m*16+5, kind 2: every lane 0x010
  task automatic send(input int kind);
    for (int m = 0; m < LANES; m++)
      ord[m] = kind == 0 ? 12'(m * 256) : kind == 1 ? 12'(m * 16 + 5) : 12'h010;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency", 32'(out_valid), 0);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_done = 1'b0; clr = 1'b0;
    ord = '{default: '0};
    #1 rst = 1'b0;
    #11;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_conf", 32'(conflict), 0);
    chk("rst_cnt", 32'(group_cnt), 0);
    chk("rst_done", 32'(map_done), 0);
    chk("rst_sel", 32'(lane_sel[3]), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(0);
    for (int m = 0; m < LANES; m++) begin
      chk("s0_bank", 32'(bank_idx[m]), 32'(m));
      chk("s0_addr", 32'(bank_addr[m]), 32'(m * 16));
      chk("s0_sel", 32'(lane_sel[m]), 32'(m));
    end
    chk("s0_conf", 32'(conflict), 0);
    chk("s0_cnt", 32'(group_cnt), 1);
    @(negedge clk);
    chk("bubble_ov", 32'(out_valid), 0);
    chk("bubble_hold", 32'(bank_idx[7]), 7);
    send(1);
    for (int m = 0; m < LANES; m++) begin
      chk("s1_bank", 32'(bank_idx[m]), 32'((m + 5) % 16));
      chk("s1_addr", 32'(bank_addr[m]), 32'(m));
      chk("s1_sel", 32'(lane_sel[m]), 32'((m + 11) % 16));
    end
    chk("s1_sel0", 32'(lane_sel[0]), 11);
    chk("s1_sel5", 32'(lane_sel[5]), 0);
    chk("s1_cnt", 32'(group_cnt), 2);
    send(2);
    chk("cf_conf", 32'(conflict), 1);
    for (int m = 0; m < LANES; m++) begin
      chk("cf_bank", 32'(bank_idx[m]), 1);
      chk("cf_addr", 32'(bank_addr[m]), 1);
      chk("cf_sel", 32'(lane_sel[m]), 0);
    end
    send(0);
    chk("cf_hold", 32'(conflict), 1);
    chk("cf_cnt", 32'(group_cnt), 4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_conf", 32'(conflict), 0);
    chk("clr_cnt", 32'(group_cnt), 0);
    in_done = 1'b1;
    @(negedge clk);
    in_done = 1'b0;
    chk("lone_done1", 32'(map_done), 0);
    @(negedge clk);
    chk("lone_done2", 32'(map_done), 0);
    for (int s = 0; s < 768 + 3; s++) begin
      @(negedge clk);
      if (out_valid) begin
        ovc++;
        occ = '0;
        for (int m = 0; m < LANES; m++) occ[bank_idx[m]] = 1'b1;
        chk("perm", 32'(occ), 32'hFFFF);
      end
      if (map_done) begin
        dn++;
        dpos = ovc;
      end
      if (s < 768) begin
        int l, g, lo, hi;
        l = s / 256; g = s % 256; lo = g % 16; hi = g / 16;
        for (int m = 0; m < LANES; m++)
          ord[m] = l == 0 ? 12'(hi * 256 + lo * 16 + m) :
                   l == 1 ? 12'(hi * 256 + m * 16 + lo) : 12'(m * 256 + hi * 16 + lo);
        in_valid = 1'b1;
        in_done  = s == 767;
      end else begin
        in_valid = 1'b0;
        in_done  = 1'b0;
      end
    end
    chk("pass_ov", 32'(ovc), 768);
    chk("pass_cnt", 32'(group_cnt), 768);
    chk("pass_done_n", 32'(dn), 1);
    chk("pass_done_pos", 32'(dpos), 768);
    chk("pass_conf", 32'(conflict), 0);
    for (int m = 0; m < LANES; m++) ord[m] = 12'(m * 256);
    in_valid = 1'b1;
    @(negedge clk);
    for (int m = 0; m < LANES; m++) ord[m] = 12'(m * 16 + 5);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_ov", 32'(out_valid), 0);
    chk("mrst_cnt", 32'(group_cnt), 0);
    chk("mrst_bank", 32'(bank_idx[5]), 0);
    chk("mrst_addr", 32'(bank_addr[5]), 0);
    chk("mrst_sel", 32'(lane_sel[3]), 0);
    chk("mrst_done", 32'(map_done), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stale_ov", 32'(out_valid), 0);
    end
    chk("stale_cnt", 32'(group_cnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
